// File: rtl/prediction_pkg.sv
// Shared types for the ASL prediction path.
//   stab_state_t : stabilizer FSM states
//   class_idx_t  : argmax class index
//   score_t      : signed int8 argmax score
package prediction_pkg;

    localparam int unsigned NUM_ASL_CLASSES = 24;
    localparam int unsigned CLASS_W         = 5;
    localparam int unsigned SCORE_W         = 8;

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        LOCKED
    } stab_state_t;

    typedef logic [CLASS_W-1:0]        class_idx_t;
    typedef logic signed [SCORE_W-1:0] score_t;

endpackage

// File: rtl/prediction_stabilizer.sv
// Debounces the per-frame argmax result into a stable letter label.
// A label locks after HOLD_COUNT consecutive agreeing confident frames,
// switches when a challenger gathers HOLD_COUNT agreeing confident frames,
// and releases after TIMEOUT_FRAMES consecutive non-confident frames.
//
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   in_valid     : one-cycle strobe for a new frame result
//   in_index     : argmax class index
//   in_data      : argmax score, two's complement
//   clear        : synchronous flush to IDLE (beats in_valid, no pulse)
//   out_valid    : one-cycle pulse when out_locked or out_index changes
//   out_index    : current locked label
//   out_conf     : score of the latest confident frame of the locked label
//   out_locked   : high while a label is held
module prediction_stabilizer
    import prediction_pkg::*;
#(
    parameter int unsigned NUM_CLASSES    = NUM_ASL_CLASSES,
    parameter int          MIN_CONF       = 16,
    parameter int unsigned HOLD_COUNT     = 4,
    parameter int unsigned TIMEOUT_FRAMES = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    input  logic [CLASS_W-1:0] in_index,
    input  logic [SCORE_W-1:0] in_data,
    input  logic               clear,
    output logic               out_valid,
    output logic [CLASS_W-1:0] out_index,
    output logic [SCORE_W-1:0] out_conf,
    output logic               out_locked
);

    localparam int unsigned CAND_W = $clog2(HOLD_COUNT + 1);
    localparam int unsigned MISS_W = $clog2(TIMEOUT_FRAMES + 1);
    localparam int unsigned IDXC_W = CLASS_W + 1;
    localparam score_t      MIN_SCORE = score_t'(MIN_CONF);

    stab_state_t        state_q, state_d;
    class_idx_t         cand_idx_q, cand_idx_d;
    logic [CAND_W-1:0]  cand_cnt_q, cand_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic               out_valid_d;
    class_idx_t         out_index_d;
    logic [SCORE_W-1:0] out_conf_d;
    logic               out_locked_d;

    logic               conf_hit_c;
    logic               miss_c;
    logic [CAND_W-1:0]  cand_next_c;
    logic               cand_done_c;
    logic [MISS_W-1:0]  miss_next_c;
    logic               miss_done_c;

    // Frame qualification and counter look-ahead
    always_comb begin
        conf_hit_c  = in_valid
                    && (score_t'(in_data) >= MIN_SCORE)
                    && (IDXC_W'(in_index) < IDXC_W'(NUM_CLASSES));
        miss_c      = in_valid && !conf_hit_c;
        // An idle or freshly reset counter is 0, so a match and a restart both yield 1.
        cand_next_c = (in_index == cand_idx_q) ? (cand_cnt_q + CAND_W'(1)) : CAND_W'(1);
        cand_done_c = (cand_next_c == CAND_W'(HOLD_COUNT));
        miss_next_c = (miss_cnt_q == MISS_W'(TIMEOUT_FRAMES)) ? miss_cnt_q
                                                              : (miss_cnt_q + MISS_W'(1));
        miss_done_c = (miss_next_c == MISS_W'(TIMEOUT_FRAMES));
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cand_idx_d   = cand_idx_q;
        cand_cnt_d   = cand_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        out_valid_d  = 1'b0;
        out_index_d  = out_index;
        out_conf_d   = out_conf;
        out_locked_d = out_locked;

        if (clear) begin
            state_d      = IDLE;
            cand_idx_d   = '0;
            cand_cnt_d   = '0;
            miss_cnt_d   = '0;
            out_index_d  = '0;
            out_conf_d   = '0;
            out_locked_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, CAND: begin
                    if (conf_hit_c) begin
                        cand_idx_d = in_index;
                        if (cand_done_c) begin
                            out_index_d  = in_index;
                            out_conf_d   = in_data;
                            out_locked_d = 1'b1;
                            out_valid_d  = 1'b1;
                            miss_cnt_d   = '0;
                            cand_cnt_d   = '0;
                            state_d      = LOCKED;
                        end else begin
                            cand_cnt_d = cand_next_c;
                            state_d    = CAND;
                        end
                    end else if (miss_c) begin
                        cand_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end
                LOCKED: begin
                    if (conf_hit_c) begin
                        miss_cnt_d = '0;
                        if (in_index == out_index) begin
                            cand_cnt_d = '0;
                            out_conf_d = in_data;
                        end else begin
                            cand_idx_d = in_index;
                            if (cand_done_c) begin
                                out_index_d = in_index;
                                out_conf_d  = in_data;
                                out_valid_d = 1'b1;
                                cand_cnt_d  = '0;
                            end else begin
                                cand_cnt_d = cand_next_c;
                            end
                        end
                    end else if (miss_c) begin
                        cand_cnt_d = '0;
                        if (miss_done_c) begin
                            // Label and score stay visible after release.
                            out_locked_d = 1'b0;
                            out_valid_d  = 1'b1;
                            miss_cnt_d   = '0;
                            state_d      = IDLE;
                        end else begin
                            miss_cnt_d = miss_next_c;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cand_idx_q <= '0;
            cand_cnt_q <= '0;
            miss_cnt_q <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_conf   <= '0;
            out_locked <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_idx_q <= cand_idx_d;
            cand_cnt_q <= cand_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            out_valid  <= out_valid_d;
            out_index  <= out_index_d;
            out_conf   <= out_conf_d;
            out_locked <= out_locked_d;
        end
    end

endmodule

// File: doc/prediction_stabilizer.md
Name: prediction_stabilizer

Overview:
- Sits directly downstream of the 4-input argmax stage of the ASL classifier. Consumes one winning (class index, signed int8 score) pair per inference frame.
- Emits a stable, debounced letter label for the display/UART path. A label locks only after HOLD_COUNT consecutive confident frames agree.
- Once locked, a label is released after TIMEOUT_FRAMES consecutive non-confident frames.

Parameters:
- NUM_CLASSES, 24: number of valid class indices; in_index >= NUM_CLASSES is treated as invalid.
- MIN_CONF, 16: signed int8 threshold; a frame is confident when in_data >= MIN_CONF (signed compare).
- HOLD_COUNT, 4: consecutive agreeing confident frames needed to lock or switch a label (legal range 1..15).
- TIMEOUT_FRAMES, 16: consecutive non-confident frames that release a lock (legal range 1..255).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  one-cycle strobe: in_index/in_data hold a new frame result
- in_index  in  5  argmax class index from the argmax stage
- in_data  in  8  argmax score, two's complement
- clear  in  1  synchronous flush to IDLE
- out_valid  out  1  one-cycle pulse when out_locked or out_index changes
- out_index  out  5  current locked label
- out_conf  out  8  score of the most recent confident frame of the locked label
- out_locked  out  1  1 while a label is held

Behaviour:
- Reset (async, resetn=0):
  - State = IDLE; all counters = 0.
  - out_valid=0, out_index=0, out_conf=0, out_locked=0.
- Frame qualification:
  - conf_hit = in_valid & (signed in_data >= MIN_CONF) & (in_index < NUM_CLASSES).
  - miss = in_valid & ~conf_hit.
  - Cycles with in_valid=0 change nothing.
- Latency: outputs update on the clock edge that samples the triggering in_valid. out_valid is high for exactly that following cycle.
- States:
  - IDLE:
    - conf_hit: cand_idx<=in_index, cand_cnt<=1, go CAND.
    - If HOLD_COUNT==1, lock immediately instead (see lock action).
  - CAND:
    - conf_hit with in_index==cand_idx: cand_cnt++. When the count reaches HOLD_COUNT, perform the lock action and go LOCKED.
    - conf_hit with a different index: cand_idx<=in_index, cand_cnt<=1.
    - miss: go IDLE, cand_cnt<=0.
  - LOCKED:
    - conf_hit with in_index==out_index: miss_cnt<=0, cand_cnt<=0, out_conf<=in_data, no pulse.
    - conf_hit with a different index: miss_cnt<=0. Track the challenger exactly as in CAND, using cand_idx/cand_cnt.
      - When the challenger reaches HOLD_COUNT: out_index<=cand_idx, out_conf<=in_data, pulse out_valid, cand_cnt<=0. Stay LOCKED.
      - A conf_hit of the locked label resets cand_cnt to 0.
    - miss: miss_cnt++ (saturating); cand_cnt<=0. When miss_cnt reaches TIMEOUT_FRAMES:
      - out_locked<=0; out_index and out_conf keep their values.
      - Pulse out_valid, go IDLE, miss_cnt<=0.
- Lock action: out_index<=cand_idx, out_conf<=in_data, out_locked<=1, out_valid pulse, miss_cnt<=0, cand_cnt<=0.
- clear:
  - Highest synchronous priority; overrides a simultaneous in_valid.
  - Returns to IDLE with all counters and outputs at reset values, with no out_valid pulse.
- Counter widths:
  - cand_cnt: $clog2(HOLD_COUNT+1) bits.
  - miss_cnt: $clog2(TIMEOUT_FRAMES+1) bits.
  - Neither counter ever wraps.
- Signed compare: compare in_data as signed, or equivalently compare {~in_data[7], in_data[6:0]} against the same transform of MIN_CONF. in_data=8'h80 (-128) is never confident unless MIN_CONF=-128.
- Back-to-back in_valid on consecutive cycles must be handled at full rate.

Decomposition:
- Package prediction_pkg:
  - typedef enum logic [1:0] {IDLE, CAND, LOCKED} stab_state_t
  - typedef logic [4:0] class_idx_t
  - typedef logic signed [7:0] score_t
  - localparam NUM_ASL_CLASSES = 24
- No sub-module is needed. A single FSM-plus-counters module is natural.

Test Plan (defaults: HOLD_COUNT=4, MIN_CONF=16, TIMEOUT_FRAMES=16):
- Reset: hold resetn=0 mid-frame, then release -> all outputs 0, state IDLE, no out_valid pulse.
- Lock: 4 frames of idx=7, data=40 -> after the 4th: out_valid pulse, out_locked=1, out_index=7, out_conf=40. Only 3 frames -> no lock.
- Interrupted candidate:
  - idx 3,3,3 then data=10 (miss) then 3,3,3 (data 50) -> no lock.
  - A 4th frame of idx 3 -> lock on index 3.
  - Also: idx 5,5,9,9,9,9 -> locks 9, never 5.
- Switch while locked: locked on 7; send idx 12 x3, then 7 x1, then 12 x4 -> label stays 7 until the last frame, then out_index=12 with one pulse. out_locked stays 1 throughout.
- Timeout and boundaries:
  - Locked on 7; 15 misses (data=-128, or idx=30 with data=100) -> still locked.
  - 16th miss -> out_locked=0, out_index=7, pulse.
  - data=16 counts as confident; data=15 does not.
- clear: assert clear together with in_valid on the 4th agreeing frame -> no lock, no pulse, outputs 0. The next 4 agreeing frames lock normally.
